mac_lane_array: RTL and testbench

- Parametrised, multi-lane integer multiply-accumulate engine; successor to the single 16-bit MAC lane.
- Generalised in operand width, lane count and accumulator width.
- Adds valid/ready handshakes on input and output, dot-product grouping via a last flag, sticky overflow reporting and a result FIFO with backpressure.
- Sits between the operand streamer and the result collector on the MAC datapath.

---
 rtl/mac_lane_array.sv | 243 ++++++++++++++++++++++++
 tb/tb_mac_lane_array.sv | 283 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mac_lane_array.sv
// mac_lane_array: multi-lane integer multiply-accumulate engine.
// Operand beats arrive on a valid/ready handshake, are multiplied per lane in
// stage S1, accumulated in stage S2 and, on the last beat of a dot-product
// group, written with sticky overflow flags into a first-word fall-through
// result FIFO. Input acceptance is credit-limited so the FIFO never overflows.
module mac_lane_array #(
    parameter int DATA_W     = 16,
    parameter int LANES      = 4,
    parameter int ACC_W      = 40,
    parameter int FIFO_DEPTH = 4
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      in_vld,
    output logic                      in_rdy,
    input  logic [LANES*DATA_W-1:0]   in_a,
    input  logic [LANES*DATA_W-1:0]   in_b,
    input  logic                      in_mode,
    input  logic                      in_last,
    input  logic                      cfg_clr,
    output logic                      out_vld,
    input  logic                      out_rdy,
    output logic [LANES*ACC_W-1:0]    out_c,
    output logic [LANES-1:0]          out_ovf,
    output logic                      out_mode
);

    localparam int PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int CNT_W = PTR_W + 1;
    localparam int PRD_W = 2 * DATA_W;

    // Handshake and group-mode tracking
    logic               accept;
    logic               effMode;
    logic               grpOpen_q, grpOpen_d;
    logic               grpMode_q, grpMode_d;

    // Stage S1: registered products
    logic               s1Vld_q,  s1Vld_d;
    logic               s1Last_q, s1Last_d;
    logic               s1Mode_q, s1Mode_d;
    logic [ACC_W-1:0]   prodExt  [LANES];
    logic [ACC_W-1:0]   s1Prod_q [LANES];
    logic [ACC_W-1:0]   s1Prod_d [LANES];

    // Stage S2: accumulators and sticky overflow
    logic [ACC_W-1:0]   acc_q   [LANES];
    logic [ACC_W-1:0]   acc_d   [LANES];
    logic [ACC_W-1:0]   accNext [LANES];
    logic [LANES-1:0]   ovf_q, ovf_d;
    logic [LANES-1:0]   ovfNext;

    // Result FIFO
    logic [LANES*ACC_W-1:0] fifoC_q    [FIFO_DEPTH];
    logic [LANES-1:0]       fifoOvf_q  [FIFO_DEPTH];
    logic                   fifoMode_q [FIFO_DEPTH];
    logic [PTR_W-1:0]       wrPtr_q, wrPtr_d;
    logic [PTR_W-1:0]       rdPtr_q, rdPtr_d;
    logic [CNT_W-1:0]       count_q, count_d;
    logic                   push;
    logic                   pop;
    logic [LANES*ACC_W-1:0] pushC;
    logic                   pendingLast;
    logic [CNT_W:0]         creditUse;

    // A beat whose group is not yet open takes its mode straight from in_mode,
    // which also covers single-beat groups.
    assign effMode = grpOpen_q ? grpMode_q : in_mode;
    assign accept  = in_vld && in_rdy;

    // A last beat still in S1 has already claimed a FIFO slot, so it counts
    // against the credit even before it is written.
    assign pendingLast = s1Vld_q && s1Last_q;
    assign creditUse   = {1'b0, count_q} + (CNT_W+1)'(pendingLast);
    assign in_rdy      = rst_n && !cfg_clr && (creditUse < (CNT_W+1)'(FIFO_DEPTH));

    assign push = s1Vld_q && s1Last_q && !cfg_clr;
    assign pop  = out_vld && out_rdy && !cfg_clr;

    genvar g;
    generate
        for (g = 0; g < LANES; g++) begin : gLane
            logic [DATA_W-1:0] laneA;
            logic [DATA_W-1:0] laneB;
            logic [PRD_W-1:0]  aExt;
            logic [PRD_W-1:0]  bExt;
            logic [PRD_W-1:0]  prod;
            logic [ACC_W:0]    sum;
            logic              addOvf;

            assign laneA = in_a[g*DATA_W +: DATA_W];
            assign laneB = in_b[g*DATA_W +: DATA_W];

            // Extending both operands to 2*DATA_W and keeping the low half of
            // the product gives the exact signed or unsigned product.
            assign aExt = {{DATA_W{effMode & laneA[DATA_W-1]}}, laneA};
            assign bExt = {{DATA_W{effMode & laneB[DATA_W-1]}}, laneB};
            assign prod = aExt * bExt;

            if (ACC_W > PRD_W) begin : gWiden
                assign prodExt[g] = {{(ACC_W-PRD_W){effMode & prod[PRD_W-1]}}, prod};
            end else begin : gSame
                assign prodExt[g] = prod;
            end

            // The add wraps modulo 2^ACC_W; overflow is judged by the mode
            // the product was formed in.
            assign sum        = {1'b0, acc_q[g]} + {1'b0, s1Prod_q[g]};
            assign accNext[g] = sum[ACC_W-1:0];
            assign addOvf     = s1Mode_q
                              ? ((acc_q[g][ACC_W-1] == s1Prod_q[g][ACC_W-1]) &&
                                 (sum[ACC_W-1] != acc_q[g][ACC_W-1]))
                              : sum[ACC_W];
            assign ovfNext[g] = ovf_q[g] | addOvf;
            assign pushC[g*ACC_W +: ACC_W] = accNext[g];
        end
    endgenerate

    // Next-state for the group-mode latch: opens on a non-last beat, closes on
    // a last beat or flush.
    always_comb begin
        grpOpen_d = grpOpen_q;
        grpMode_d = grpMode_q;
        if (cfg_clr) begin
            grpOpen_d = 1'b0;
        end else if (accept) begin
            grpOpen_d = !in_last;
            grpMode_d = effMode;
        end
    end

    // Next-state for stage S1; product registers only load on an accepted beat.
    always_comb begin
        s1Vld_d  = accept && !cfg_clr;
        s1Last_d = s1Last_q;
        s1Mode_d = s1Mode_q;
        s1Prod_d = s1Prod_q;
        if (accept) begin
            s1Last_d = in_last;
            s1Mode_d = effMode;
            s1Prod_d = prodExt;
        end
    end

    // Next-state for stage S2: accumulate, or restart after a group completes.
    always_comb begin
        acc_d = acc_q;
        ovf_d = ovf_q;
        if (cfg_clr) begin
            for (int i = 0; i < LANES; i++) begin
                acc_d[i] = '0;
            end
            ovf_d = '0;
        end else if (s1Vld_q) begin
            if (s1Last_q) begin
                for (int i = 0; i < LANES; i++) begin
                    acc_d[i] = '0;
                end
                ovf_d = '0;
            end else begin
                acc_d = accNext;
                ovf_d = ovfNext;
            end
        end
    end

    // Next-state for FIFO pointers and occupancy; push and pop together leave
    // the count unchanged.
    always_comb begin
        wrPtr_d = wrPtr_q;
        rdPtr_d = rdPtr_q;
        count_d = count_q;
        if (cfg_clr) begin
            wrPtr_d = '0;
            rdPtr_d = '0;
            count_d = '0;
        end else begin
            if (push) begin
                wrPtr_d = wrPtr_q + PTR_W'(1);
            end
            if (pop) begin
                rdPtr_d = rdPtr_q + PTR_W'(1);
            end
            case ({push, pop})
                2'b10:   count_d = count_q + CNT_W'(1);
                2'b01:   count_d = count_q - CNT_W'(1);
                default: count_d = count_q;
            endcase
        end
    end

    // Control and pipeline state registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            grpOpen_q <= 1'b0;
            grpMode_q <= 1'b0;
            s1Vld_q   <= 1'b0;
            s1Last_q  <= 1'b0;
            s1Mode_q  <= 1'b0;
            ovf_q     <= '0;
            wrPtr_q   <= '0;
            rdPtr_q   <= '0;
            count_q   <= '0;
            for (int i = 0; i < LANES; i++) begin
                s1Prod_q[i] <= '0;
                acc_q[i]    <= '0;
            end
        end else begin
            grpOpen_q <= grpOpen_d;
            grpMode_q <= grpMode_d;
            s1Vld_q   <= s1Vld_d;
            s1Last_q  <= s1Last_d;
            s1Mode_q  <= s1Mode_d;
            ovf_q     <= ovf_d;
            wrPtr_q   <= wrPtr_d;
            rdPtr_q   <= rdPtr_d;
            count_q   <= count_d;
            s1Prod_q  <= s1Prod_d;
            acc_q     <= acc_d;
        end
    end

    // FIFO storage; cleared on reset so the outputs read zero while in reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < FIFO_DEPTH; i++) begin
                fifoC_q[i]    <= '0;
                fifoOvf_q[i]  <= '0;
                fifoMode_q[i] <= 1'b0;
            end
        end else if (push) begin
            fifoC_q[wrPtr_q]    <= pushC;
            fifoOvf_q[wrPtr_q]  <= ovfNext;
            fifoMode_q[wrPtr_q] <= s1Mode_q;
        end
    end

    assign out_vld  = (count_q != '0);
    assign out_c    = fifoC_q[rdPtr_q];
    assign out_ovf  = fifoOvf_q[rdPtr_q];
    assign out_mode = fifoMode_q[rdPtr_q];

endmodule

// File: tb/tb_mac_lane_array.sv
// Scoreboard testbench for mac_lane_array: expected group results are queued
// when stimulus is issued and a monitor compares them as the DUT pops results.
module tb_mac_lane_array;

    localparam int DATA_W     = 16;
    localparam int LANES      = 4;
    localparam int ACC_W      = 40;
    localparam int FIFO_DEPTH = 4;
    localparam int AW         = LANES * DATA_W;
    localparam int CW         = LANES * ACC_W;

    typedef struct packed {
        logic [CW-1:0]    c;
        logic [LANES-1:0] ovf;
        logic             mode;
    } expT;

    logic             clk;
    logic             rst_n;
    logic             in_vld;
    logic             in_rdy;
    logic [AW-1:0]    in_a;
    logic [AW-1:0]    in_b;
    logic             in_mode;
    logic             in_last;
    logic             cfg_clr;
    logic             out_vld;
    logic             out_rdy;
    logic [CW-1:0]    out_c;
    logic [LANES-1:0] out_ovf;
    logic             out_mode;

    expT sbQ[$];
    expT monE;
    int  checks = 0;
    int  passes = 0;
    int  acceptCount = 0;

    mac_lane_array #(
        .DATA_W     (DATA_W),
        .LANES      (LANES),
        .ACC_W      (ACC_W),
        .FIFO_DEPTH (FIFO_DEPTH)
    ) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .in_vld   (in_vld),
        .in_rdy   (in_rdy),
        .in_a     (in_a),
        .in_b     (in_b),
        .in_mode  (in_mode),
        .in_last  (in_last),
        .cfg_clr  (cfg_clr),
        .out_vld  (out_vld),
        .out_rdy  (out_rdy),
        .out_c    (out_c),
        .out_ovf  (out_ovf),
        .out_mode (out_mode)
    );

    // Free-running 10-time-unit clock
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Overall time bound so the run can never hang
    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation still running at %0t, required to finish earlier", $time);
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic checkOutput(input string name, input logic [CW-1:0] actual,
                               input logic [CW-1:0] expected);
        checks++;
        if (actual === expected) begin
            passes++;
        end else begin
            $display("[TB] FAIL %s: got %h, expected %h", name, actual, expected);
        end
    endtask

    function automatic logic [AW-1:0] lane0Op(input logic [DATA_W-1:0] v);
        return {{(AW-DATA_W){1'b0}}, v};
    endfunction

    function automatic logic [CW-1:0] lane0Acc(input logic [ACC_W-1:0] v);
        return {{(CW-ACC_W){1'b0}}, v};
    endfunction

    task automatic expectResult(input logic [CW-1:0] c, input logic [LANES-1:0] ovf,
                                input logic mode);
        expT e;
        e.c    = c;
        e.ovf  = ovf;
        e.mode = mode;
        sbQ.push_back(e);
    endtask

    // Drive one beat and hold it until the DUT accepts it (bounded)
    task automatic applyStimulus(input logic [AW-1:0] a, input logic [AW-1:0] b,
                                 input logic mode, input logic last);
        logic accepted;
        in_a     = a;
        in_b     = b;
        in_mode  = mode;
        in_last  = last;
        in_vld   = 1'b1;
        accepted = 1'b0;
        for (int n = 0; n < 50 && !accepted; n++) begin
            @(negedge clk);
            accepted = in_rdy;
            @(posedge clk);
            #1;
        end
        in_vld = 1'b0;
        if (!accepted) begin
            checks++;
            $display("[TB] FAIL accept_timeout: in_rdy stayed %b, required 1", in_rdy);
        end
    endtask

    // Wait (bounded) for every queued expectation to be consumed
    task automatic waitDrain(input string name);
        for (int n = 0; n < 100 && sbQ.size() != 0; n++) begin
            @(posedge clk);
        end
        #1;
        checks++;
        if (sbQ.size() == 0) begin
            passes++;
        end else begin
            $display("[TB] FAIL %s: %0d results still outstanding, expected 0", name, sbQ.size());
        end
    endtask

    // Monitor: compare each popped result against the scoreboard head, and
    // count accepted input beats
    always @(negedge clk) begin
        if (rst_n && out_vld && out_rdy) begin
            if (sbQ.size() == 0) begin
                checks++;
                $display("[TB] FAIL unexpected_result: got out_c %h, expected no result", out_c);
            end else begin
                monE = sbQ.pop_front();
                checkOutput("out_c", out_c, monE.c);
                checkOutput("out_ovf", CW'(out_ovf), CW'(monE.ovf));
                checkOutput("out_mode", CW'(out_mode), CW'(monE.mode));
            end
        end
        if (rst_n && in_vld && in_rdy) begin
            acceptCount++;
        end
    end

    initial begin
        rst_n   = 1'b0;
        in_vld  = 1'b0;
        in_a    = '0;
        in_b    = '0;
        in_mode = 1'b0;
        in_last = 1'b0;
        cfg_clr = 1'b0;
        out_rdy = 1'b1;

        // Reset state
        repeat (2) @(posedge clk);
        #1;
        checkOutput("rst_out_vld", CW'(out_vld), '0);
        checkOutput("rst_in_rdy", CW'(in_rdy), '0);
        checkOutput("rst_out_c", out_c, '0);
        checkOutput("rst_out_ovf", CW'(out_ovf), '0);
        checkOutput("rst_out_mode", CW'(out_mode), '0);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        // Signed three-beat group: -10 - 12 + 700 = 678; later beats drive mode 0
        $display("[TB] test 1: signed dot product");
        expectResult(lane0Acc(40'd678), '0, 1'b1);
        applyStimulus(lane0Op(16'hFFFE), lane0Op(16'd5), 1'b1, 1'b0);
        applyStimulus(lane0Op(16'd3), lane0Op(16'hFFFC), 1'b0, 1'b0);
        applyStimulus(lane0Op(16'd100), lane0Op(16'd7), 1'b0, 1'b1);
        checkOutput("t1_vld_after_E0", CW'(out_vld), '0);
        @(posedge clk);
        #1;
        checkOutput("t1_vld_after_E1", CW'(out_vld), CW'(1));
        waitDrain("t1_drain");

        // Unsigned single beat on all lanes: 0xFFFF * 0xFFFF
        $display("[TB] test 2: unsigned all lanes");
        expectResult({LANES{40'h00FFFE0001}}, '0, 1'b0);
        applyStimulus({LANES{16'hFFFF}}, {LANES{16'hFFFF}}, 1'b0, 1'b1);
        waitDrain("t2_drain");

        // Backpressure: only FIFO_DEPTH groups may be in flight
        $display("[TB] test 3: backpressure");
        out_rdy     = 1'b0;
        acceptCount = 0;
        for (int k = 1; k <= 6; k++) begin
            expectResult(lane0Acc(ACC_W'(k)), '0, 1'b0);
        end
        for (int k = 1; k <= 4; k++) begin
            applyStimulus(lane0Op(DATA_W'(k)), lane0Op(16'd1), 1'b0, 1'b1);
        end
        in_a    = lane0Op(16'd5);
        in_b    = lane0Op(16'd1);
        in_mode = 1'b0;
        in_last = 1'b1;
        in_vld  = 1'b1;
        repeat (6) @(posedge clk);
        @(negedge clk);
        checkOutput("t3_in_rdy_stalled", CW'(in_rdy), '0);
        checkOutput("t3_accept_count", CW'(acceptCount), CW'(4));
        checkOutput("t3_out_vld_full", CW'(out_vld), CW'(1));
        @(posedge clk);
        #1;
        out_rdy = 1'b1;
        applyStimulus(lane0Op(16'd5), lane0Op(16'd1), 1'b0, 1'b1);
        applyStimulus(lane0Op(16'd6), lane0Op(16'd1), 1'b0, 1'b1);
        waitDrain("t3_drain");

        // Signed overflow: 512 * 2^30 = 2^39 exceeds the signed 40-bit range
        $display("[TB] test 4: signed overflow");
        expectResult(lane0Acc(40'h8000000000), 4'b0001, 1'b1);
        for (int i = 0; i < 512; i++) begin
            applyStimulus(lane0Op(16'h8000), lane0Op(16'h8000), (i == 0), (i == 511));
        end
        expectResult(lane0Acc(40'd1), '0, 1'b1);
        applyStimulus(lane0Op(16'd1), lane0Op(16'd1), 1'b1, 1'b1);
        waitDrain("t4_drain");

        // Flush with an unread result and a partial group in flight
        $display("[TB] test 5: flush");
        out_rdy = 1'b0;
        applyStimulus(lane0Op(16'd7), lane0Op(16'd1), 1'b0, 1'b1);
        repeat (2) @(posedge clk);
        #1;
        checkOutput("t5_vld_before_flush", CW'(out_vld), CW'(1));
        for (int i = 0; i < 3; i++) begin
            applyStimulus(lane0Op(16'd10), lane0Op(16'd10), 1'b0, 1'b0);
        end
        cfg_clr = 1'b1;
        @(negedge clk);
        checkOutput("t5_rdy_during_clr", CW'(in_rdy), '0);
        @(posedge clk);
        #1;
        cfg_clr = 1'b0;
        checkOutput("t5_vld_after_flush", CW'(out_vld), '0);
        out_rdy = 1'b1;
        expectResult(lane0Acc(40'd6), '0, 1'b0);
        applyStimulus(lane0Op(16'd2), lane0Op(16'd3), 1'b0, 1'b1);
        waitDrain("t5_drain");

        // Asynchronous reset between clock edges with a result and open group
        $display("[TB] test 6: async reset");
        out_rdy = 1'b0;
        applyStimulus(lane0Op(16'd3), lane0Op(16'd3), 1'b0, 1'b1);
        applyStimulus(lane0Op(16'd9), lane0Op(16'd9), 1'b0, 1'b0);
        @(posedge clk);
        #1;
        checkOutput("t6_vld_before_reset", CW'(out_vld), CW'(1));
        #2;
        rst_n = 1'b0;
        #1;
        checkOutput("t6_vld_in_reset", CW'(out_vld), '0);
        checkOutput("t6_rdy_in_reset", CW'(in_rdy), '0);
        checkOutput("t6_out_c_in_reset", out_c, '0);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        out_rdy = 1'b1;
        expectResult(lane0Acc(40'd20), '0, 1'b0);
        applyStimulus(lane0Op(16'd4), lane0Op(16'd5), 1'b0, 1'b1);
        waitDrain("t6_drain");

        repeat (3) @(posedge clk);
        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
